result_display_sequencer: RTL
=============================

# result_display_sequencer

Controller that sequences one signed 16-bit multiplier result through the sign/magnitude stage and then the binary-to-BCD stage. It launches each stage with a one-cycle valid pulse, waits for each ready, and latches the final BCD code and sign into a stable holding register for the display multiplexer. It sits between the multiplier output and the sign_magnitude / binary_BCD / display_multiplexer chain, replacing the constant-valid drive at top level.

## Interface
Parameters:
- DATA_W, 16, result and BCD width
- MAX_MAG, 9999, largest magnitude displayable on 4 digits
- TIMEOUT_CYC, 255, per-stage wait limit (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  new result offered
- in_data  in  DATA_W  two's-complement result
- in_ready  out  1  sequencer can accept
- sm_valid  out  1  one-cycle start pulse to sign_magnitude
- sm_result  out  DATA_W  captured result to sign_magnitude
- sm_magnitude  in  DATA_W  magnitude from sign_magnitude
- sm_sign  in  1  sign from sign_magnitude
- sm_ready  in  1  sign_magnitude done
- bcd_valid  out  1  one-cycle start pulse to binary_BCD
- bcd_value  out  DATA_W  captured magnitude to binary_BCD
- bcd_ready  in  1  binary_BCD done
- bcd_code  in  DATA_W  4-digit BCD from binary_BCD
- disp_valid  out  1  holding register valid (level)
- disp_bcd  out  DATA_W  held BCD code
- disp_sign  out  1  held sign, 1 = negative
- disp_overflow  out  1  held magnitude exceeded MAX_MAG
- busy  out  1  conversion in progress
- error  out  1  sticky stage-timeout flag

## Operation
- FSM states: IDLE, SM_START, SM_WAIT, BCD_START, BCD_WAIT, UPDATE.
- IDLE: in_ready=1. When in_valid is high, capture in_data into sm_result and go to SM_START.
- SM_START: sm_valid=1 for exactly one cycle, then go to SM_WAIT.
- SM_WAIT: on sm_ready, capture sm_magnitude into bcd_value and sm_sign into a sign register. Set the overflow register to (sm_magnitude > MAX_MAG). Go to BCD_START.
- BCD_START: bcd_valid=1 for exactly one cycle, then go to BCD_WAIT.
- BCD_WAIT: on bcd_ready, go to UPDATE.
- UPDATE: for one cycle, load disp_bcd from bcd_code (or 16'h9999 when overflow), disp_sign, disp_overflow, and set disp_valid=1. Return to IDLE.
- -32768 has magnitude 32768, which gives overflow=1, disp_bcd=16'h9999, disp_sign=1.
- Zero gives disp_bcd=0 and disp_sign=0.
- in_valid outside IDLE is ignored (in_ready=0); no queueing.
- The display holding register changes only in UPDATE. disp_valid stays 1 until reset.
- busy=1 in every state except IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert): state=IDLE. All outputs are 0: in_ready=0 while rst is asserted, then 1 in IDLE. disp_bcd=0, disp_sign=0, disp_overflow=0, disp_valid=0, error=0.
- Accept cycle T (in_valid & in_ready) gives sm_valid at T+1.
- Fastest path: stage ready in the cycle after the start pulse gives disp update visible at T+6. in_ready returns at T+6.
- Ready strobes outside the matching WAIT state are ignored.
- sm_ready and bcd_ready are treated as pulses or levels; only the first edge seen in a WAIT state counts.
- Reset mid-conversion aborts immediately. The holding register is cleared and there is no partial update.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in SM_WAIT and BCD_WAIT and clears on state entry.
  - Reaching TIMEOUT_CYC sets error (sticky until reset) and returns to IDLE without updating the display.
- SEQ_TIMEOUT_EN undefined:
  - No counter; WAIT states wait indefinitely.
  - error is tied to 0.

## Structure
- Shared package result_seq_pkg holds:
  - the state enum seq_state_t
  - the constants MAX_MAG_DEFAULT and BCD_SATURATE (16'h9999)
- Optional sub-module stage_timer: the timeout counter, instantiated only under SEQ_TIMEOUT_EN. Everything else stays flat.

## Test plan
- in_data=16'd1234; stubs return magnitude 1234 and BCD 16'h1234 one cycle after each start -> disp_bcd=16'h1234, disp_sign=0, disp_overflow=0, disp_valid=1 at T+6.
- in_data=-16'd57 (16'hFFC7) -> sm_result=16'hFFC7, bcd_value=57, disp_bcd=16'h0057, disp_sign=1.
- in_data=16'd20000 -> disp_overflow=1, disp_bcd=16'h9999, disp_sign=0.
- in_valid held high for the whole conversion with a second value on the bus -> only the first value is accepted; in_ready=0 until return to IDLE, then the second is accepted.
- rst pulsed low during BCD_WAIT with a valid display held -> all display outputs 0 and state IDLE; no bcd_valid after release.
- With SEQ_TIMEOUT_EN and sm_ready never asserted -> error=1 after TIMEOUT_CYC cycles in SM_WAIT, FSM returns to IDLE, display unchanged.

Source files
------------

// File: rtl/result_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_seq_pkg
//  Description : Shared types and constants for the result display sequencer:
//                FSM state encoding, default display limit and the BCD code
//                shown when a magnitude does not fit on four digits.
//  Revision    : 1.0  initial release
// ============================================================================
package result_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SM_START  = 3'd1,
        SM_WAIT   = 3'd2,
        BCD_START = 3'd3,
        BCD_WAIT  = 3'd4,
        UPDATE    = 3'd5
    } seq_state_t;

    localparam int          MAX_MAG_DEFAULT = 9999;
    localparam logic [15:0] BCD_SATURATE    = 16'h9999;

endpackage
`default_nettype wire

// File: rtl/stage_timer.sv
`default_nettype none
// ============================================================================
//  Module      : stage_timer
//  Description : 8-bit wait counter for one handshake stage. Counts while
//                run_i is high, holds at the limit and flags expiry; any cycle
//                with run_i low clears it, so every new wait starts from zero.
//  Ports       : clk       - system clock
//                rst       - asynchronous active-low reset
//                run_i     - high while the sequencer sits in a wait state
//                expired_o - wait limit reached in the current wait state
//  Revision    : 1.0  initial release
// ============================================================================
module stage_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else if (!run_i) begin
            count_q <= 8'd0;
        end else if (!expired_o) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired_o = run_i && (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/result_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : result_display_sequencer
//  Description : Walks one signed multiplier result through the sign/magnitude
//                stage and the binary-to-BCD stage using one-cycle start
//                pulses and ready handshakes, then latches the BCD code, sign
//                and overflow flag into a holding register for the display.
//  Build macro : SEQ_TIMEOUT_EN - adds a per-stage wait timeout with a sticky
//                error flag; when undefined, waits are unbounded, error = 0.
//  Ports       : clk, rst (async active-low)
//                in_valid/in_data/in_ready          - result input handshake
//                sm_valid/sm_result                 - start to sign_magnitude
//                sm_magnitude/sm_sign/sm_ready      - sign_magnitude return
//                bcd_valid/bcd_value                - start to binary_BCD
//                bcd_ready/bcd_code                 - binary_BCD return
//                disp_valid/disp_bcd/disp_sign/disp_overflow - held display
//                busy, error                        - status
//  Revision    : 1.0  initial release
// ============================================================================
module result_display_sequencer
    import result_seq_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MAX_MAG     = MAX_MAG_DEFAULT,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sm_valid,
    output logic [DATA_W-1:0] sm_result,
    input  logic [DATA_W-1:0] sm_magnitude,
    input  logic              sm_sign,
    input  logic              sm_ready,
    output logic              bcd_valid,
    output logic [DATA_W-1:0] bcd_value,
    input  logic              bcd_ready,
    input  logic [DATA_W-1:0] bcd_code,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_bcd,
    output logic              disp_sign,
    output logic              disp_overflow,
    output logic              busy,
    output logic              error
);

    localparam logic [DATA_W-1:0] MAX_MAG_W = DATA_W'(MAX_MAG);
    localparam logic [DATA_W-1:0] SAT_CODE  = DATA_W'(BCD_SATURATE);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] mag_q;
    logic              sign_q;
    logic              ovf_q;
    logic [DATA_W-1:0] disp_bcd_q;
    logic              disp_sign_q;
    logic              disp_ovf_q;
    logic              disp_valid_q;
    logic              timeout_w;

`ifdef SEQ_TIMEOUT_EN
    logic error_q;

    stage_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stage_timer (
        .clk       (clk),
        .rst       (rst),
        .run_i     ((state_q == SM_WAIT) || (state_q == BCD_WAIT)),
        .expired_o (timeout_w)
    );

    // A ready arriving in the expiry cycle still wins, so only an
    // unanswered wait raises the error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else if (timeout_w &&
                     ((state_q == SM_WAIT  && !sm_ready) ||
                      (state_q == BCD_WAIT && !bcd_ready))) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_w      = 1'b0;
    assign error          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Readies seen outside their own wait state fall
    // through untouched, and leaving the wait state on the first ready
    // makes a held-high ready count only once.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (in_valid) state_d = SM_START;
            SM_START:  state_d = SM_WAIT;
            SM_WAIT: begin
                if (sm_ready)       state_d = BCD_START;
                else if (timeout_w) state_d = IDLE;
            end
            BCD_START: state_d = BCD_WAIT;
            BCD_WAIT: begin
                if (bcd_ready)      state_d = UPDATE;
                else if (timeout_w) state_d = IDLE;
            end
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath captures and display holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q     <= '0;
            mag_q        <= '0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
            disp_bcd_q   <= '0;
            disp_sign_q  <= 1'b0;
            disp_ovf_q   <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                result_q <= in_data;
            end
            if (state_q == SM_WAIT && sm_ready) begin
                mag_q  <= sm_magnitude;
                sign_q <= sm_sign;
                ovf_q  <= (sm_magnitude > MAX_MAG_W);
            end
            // The BCD stage output is meaningless past four digits, so an
            // oversize magnitude shows all nines instead.
            if (state_q == UPDATE) begin
                disp_bcd_q   <= ovf_q ? SAT_CODE : bcd_code;
                disp_sign_q  <= sign_q;
                disp_ovf_q   <= ovf_q;
                disp_valid_q <= 1'b1;
            end
        end
    end

    // in_ready is gated by rst so it reads 0 while reset is held.
    assign in_ready      = (state_q == IDLE) && rst;
    assign busy          = (state_q != IDLE);
    assign sm_valid      = (state_q == SM_START);
    assign sm_result     = result_q;
    assign bcd_valid     = (state_q == BCD_START);
    assign bcd_value     = mag_q;
    assign disp_valid    = disp_valid_q;
    assign disp_bcd      = disp_bcd_q;
    assign disp_sign     = disp_sign_q;
    assign disp_overflow = disp_ovf_q;

endmodule
`default_nettype wire
